// File: rtl/cond_branch_unit.sv
// cond_branch_unit: ZNCV flag register, condition-code evaluation, 2-bit BHT prediction
// and registered mispredict redirect with a saturating mispredict counter.
module cond_branch_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flags_we,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_pred_taken,
  output logic              branch_taken,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  mispredict_count
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [3:0]        flags_q, flags_d;
  logic [1:0]        bht_q [BHT_DEPTH];
  logic              taken_q, redirect_q;
  logic [ADDR_W-1:0] rpc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              z, n, c, v, taken, accept, mis;
  logic [IDX_W-1:0]  br_idx, pred_idx;
  logic              unused_pc_bits;
  assign {z, n, c, v} = flags_q;
  assign br_idx   = br_pc[IDX_W-1:0];
  assign pred_idx = pred_pc[IDX_W-1:0];
  assign unused_pc_bits = ^{pred_pc[ADDR_W-1:IDX_W], br_pc[ADDR_W-1:IDX_W]};
  // Evaluated on the registered flags only; a same-cycle flags_we is not bypassed.
  always_comb begin
    case (br_cond)
      4'd0:    taken = 1'b1;
      4'd1:    taken = z;
      4'd2:    taken = !z;
      4'd3:    taken = c;
      4'd4:    taken = !c;
      4'd5:    taken = n;
      4'd6:    taken = !n;
      4'd7:    taken = v;
      4'd8:    taken = !v;
      4'd9:    taken = !z && (n == v);
      4'd10:   taken = n == v;
      4'd11:   taken = n != v;
      4'd12:   taken = z || (n != v);
      4'd13:   taken = c && !z;
      4'd14:   taken = !c || z;
      default: taken = 1'b0;
    endcase
  end
  // Branches arriving while a redirect is out are on the wrong path.
  assign accept  = br_valid && !redirect_q;
  assign mis     = taken != br_pred_taken;
  assign flags_d = flags_we ? {alu_result == '0, alu_result[DATA_W-1], alu_carry, alu_overflow} : flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      flags_q    <= flags_d;
      redirect_q <= accept && mis;
      if (accept) begin
        taken_q        <= taken;
        rpc_q          <= taken ? br_target : br_pc + ADDR_W'(1);
        bht_q[br_idx]  <= taken ? (bht_q[br_idx] == 2'd3 ? 2'd3 : bht_q[br_idx] + 2'd1)
                                : (bht_q[br_idx] == 2'd0 ? 2'd0 : bht_q[br_idx] - 2'd1);
        if (mis && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  assign pred_taken       = bht_q[pred_idx][1];
  assign branch_taken     = taken_q;
  assign redirect         = redirect_q;
  assign redirect_pc      = rpc_q;
  assign flags            = flags_q;
  assign mispredict_count = cnt_q;
endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
Parametrised successor to the conditional branch control. It holds the architectural Z/N/C/V flag register and evaluates a 4-bit condition code against it. It keeps a direct-mapped table of 2-bit saturating counters for fetch-stage prediction and issues a registered redirect on misprediction. It sits between the ALU/execute stage and the fetch PC logic.

Parameters:
DATA_W, 16, ALU result width; N flag = result[DATA_W-1]
ADDR_W, 16, PC width (word-addressed)
BHT_DEPTH, 16, prediction table entries; power of 2, >=2; IDX_W = log2(BHT_DEPTH)
CNT_W, 16, mispredict statistics counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
flags_we  in  1  latch new flags from ALU this edge
alu_result  in  DATA_W  ALU result; drives Z and N
alu_carry  in  1  carry-out; drives C
alu_overflow  in  1  signed overflow; drives V
pred_pc  in  ADDR_W  fetch PC to predict
pred_taken  out  1  prediction for pred_pc (combinational)
br_valid  in  1  conditional branch resolving this cycle
br_cond  in  4  condition code
br_pc  in  ADDR_W  branch PC
br_target  in  ADDR_W  taken target
br_pred_taken  in  1  prediction made at fetch for this branch
branch_taken  out  1  registered resolved outcome
redirect  out  1  registered mispredict pulse
redirect_pc  out  ADDR_W  registered correct next PC
flags  out  4  {Z,N,C,V} register
mispredict_count  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n=0): flags=0, all BHT entries=2'b01 (weakly not-taken), branch_taken=0, redirect=0, redirect_pc=0, mispredict_count=0. Reset mid-operation drops any pending redirect immediately.
- Flags: on a clk edge with flags_we=1, Z=(alu_result==0), N=alu_result[DATA_W-1], C=alu_carry, V=alu_overflow. Otherwise they hold.
- Condition codes (taken when true): 0 ALWAYS; 1 EQ Z; 2 NE !Z; 3 CS C; 4 CC !C; 5 MI N; 6 PL !N; 7 VS V; 8 VC !V; 9 GT !Z&&(N==V); 10 GE N==V; 11 LT N!=V; 12 LE Z||(N!=V); 13 HI C&&!Z; 14 LS !C||Z; 15 NEVER.
- Branch evaluation uses the registered flags, i.e. the values before any flags_we update in the same cycle. No bypass.
- Resolve, 1-cycle latency: at an edge with an accepted br_valid, register branch_taken=taken and redirect=(taken!=br_pred_taken).
  - redirect_pc = taken ? br_target : br_pc+1, computed modulo 2^ADDR_W (0xFFFF+1 gives 0x0000).
  - If there is no accepted br_valid, redirect is 0 next cycle. branch_taken and redirect_pc hold.
- Squash: a br_valid arriving in a cycle where redirect=1 is wrong-path and is ignored. It causes no BHT update, no redirect and no count.
- BHT: index = PC[IDX_W-1:0].
  - pred_taken = BHT[pred_pc idx][1].
  - On an accepted br_valid, the entry at br_pc idx increments when taken (saturates at 3) and decrements when not taken (saturates at 0). This applies to all codes, including ALWAYS/NEVER.
  - A same-cycle read and update of one index returns the old value.
- mispredict_count increments on each registered mispredict and saturates at 2^CNT_W-1 without wrapping.

Test Plan:
- Reset, then pred_pc=0x1234 -> pred_taken=0; flags=0; redirect=0; mispredict_count=0.
- flags_we with alu_result=0x0000, then br_valid cond=EQ br_pc=0x0010 br_target=0x0040 br_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x0040, branch_taken=1, count=1. pred_pc=0x0020 (idx 0) -> pred_taken=1.
- flags_we alu_result=0x8000 overflow=0 (N=1,V=0); br cond=GE pred=1 br_pc=0x0100 -> not taken, redirect=1, redirect_pc=0x0101. Same stimulus with cond=LT pred=1 -> redirect=0.
- br_pc=0xFFFF cond=NEVER pred=1 -> redirect_pc=0x0000. Same cycle flags_we with result 0 and cond=EQ -> evaluates old Z.
- Mispredict, then br_valid during the redirect cycle -> ignored: redirect=0 afterwards, count unchanged, BHT entry unchanged.
- Four taken ALWAYS branches at br_pc=0x0003 -> counter 01→10→11→11, pred_taken=1. With CNT_W=4, 17 mispredicts -> mispredict_count=15.
